// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: emits a burst of len SCLK periods at a programmable
// divisor in any CPOL/CPHA mode, with load/shift/sample strobes for the shift register.
//
// state  | meaning
// IDLE   | waiting for i_start_n low; cfg writes accepted; o_sclk parked at cpol
// ACTIVE | counting half periods and toggling o_sclk until edge 2*len
module spi_sclk_gen #(
    parameter int DIV_W = 8,
    parameter int LEN_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cfg_we,
    input  logic [DIV_W-1:0] i_cfg_div,
    input  logic [LEN_W-1:0] i_cfg_len,
    input  logic             i_cfg_cpol,
    input  logic             i_cfg_cpha,
    input  logic             i_start_n,
    output logic             o_idle,
    output logic             o_sclk,
    output logic             o_load,
    output logic             o_shift,
    output logic             o_sample,
    output logic             o_done
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_eff, half_eff, half_q;
    logic [LEN_W-1:0] len_q, len_raw;
    logic [LEN_W:0]   len_eff, bits_q;
    logic             cpol_q, cpha_q, cpol_eff, cpha_eff;
    logic             cfg_take, start_go, edge_now, leading, last_edge;
    logic             sclk_d, load_d, shift_d, sample_d, idle_d, done_d;

    // A cfg write in the start cycle must shape that very burst, so the
    // incoming fields bypass the registers while IDLE.
    assign cfg_take = (state_q == IDLE) && i_cfg_we;
    assign start_go = (state_q == IDLE) && !i_start_n;
    assign div_eff  = cfg_take ? i_cfg_div  : div_q;
    assign len_raw  = cfg_take ? i_cfg_len  : len_q;
    assign cpol_eff = cfg_take ? i_cfg_cpol : cpol_q;
    assign cpha_eff = cfg_take ? i_cfg_cpha : cpha_q;

    assign half_eff = (div_eff < DIV_W'(2)) ? DIV_W'(1) : (div_eff >> 1);
    assign len_eff  = (len_raw == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_raw};

    // bits_q counts remaining SCLK periods; the edge type comes from the
    // current level, so len = 2**LEN_W fits in LEN_W+1 bits.
    assign edge_now  = (state_q == ACTIVE) && (half_q == '0);
    assign leading   = (o_sclk == cpol_q);
    assign last_edge = edge_now && !leading && (bits_q == (LEN_W+1)'(1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!i_start_n) state_d = ACTIVE;
            ACTIVE:  if (last_edge)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sclk_d   = o_sclk;
        load_d   = 1'b0;
        shift_d  = 1'b0;
        sample_d = 1'b0;
        idle_d   = 1'b1;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                sclk_d = cpol_eff;
                load_d = !i_start_n;
                idle_d = i_start_n;
            end
            ACTIVE: begin
                idle_d = last_edge;
                done_d = last_edge;
                if (edge_now) begin
                    sclk_d = ~o_sclk;
                    if (leading) begin
                        sample_d = !cpha_q;
                        shift_d  = cpha_q;
                    end else begin
                        sample_d = cpha_q;
                        shift_d  = !cpha_q && !last_edge;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            div_q    <= DIV_W'(2);
            len_q    <= LEN_W'(8);
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            half_q   <= '0;
            bits_q   <= '0;
            o_idle   <= 1'b1;
            o_sclk   <= 1'b0;
            o_load   <= 1'b0;
            o_shift  <= 1'b0;
            o_sample <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            if (cfg_take) begin
                div_q  <= i_cfg_div;
                len_q  <= i_cfg_len;
                cpol_q <= i_cfg_cpol;
                cpha_q <= i_cfg_cpha;
            end
            if (start_go) begin
                half_q <= half_eff - DIV_W'(1);
                bits_q <= len_eff;
            end else if (state_q == ACTIVE) begin
                half_q <= edge_now ? (half_eff - DIV_W'(1)) : (half_q - DIV_W'(1));
                if (edge_now && !leading) begin
                    bits_q <= bits_q - (LEN_W+1)'(1);
                end
            end
            o_idle   <= idle_d;
            o_sclk   <= sclk_d;
            o_load   <= load_d;
            o_shift  <= shift_d;
            o_sample <= sample_d;
            o_done   <= done_d;
        end
    end

    logic unused_cpha;
    assign unused_cpha = cpha_eff;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Scoreboard bench for spi_sclk_gen: stimulus pushes the burst the model predicts,
// a monitor measures each burst between o_load and o_done and compares.
module tb_spi_sclk_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [7:0] cfg_div;
    logic [3:0] cfg_len;
    logic       cfg_cpol, cfg_cpha, start_n;
    logic       o_idle, o_sclk, o_load, o_shift, o_sample, o_done;

    always #5 clk = ~clk;

    spi_sclk_gen #(.DIV_W(8), .LEN_W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_div(cfg_div),
        .i_cfg_len(cfg_len), .i_cfg_cpol(cfg_cpol), .i_cfg_cpha(cfg_cpha),
        .i_start_n(start_n), .o_idle(o_idle), .o_sclk(o_sclk), .o_load(o_load),
        .o_shift(o_shift), .o_sample(o_sample), .o_done(o_done)
    );

    typedef struct {
        int active; int samples; int shifts; int h; int cpol; int cpha; int gap;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   m_div, m_len, m_cpol, m_cpha;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference model: what a burst should look like from the current cfg.
    task automatic push_burst(input int gap);
        exp_t e;
        int n;
        e.h       = (m_div < 2) ? 1 : m_div / 2;
        n         = (m_len == 0) ? 16 : m_len;
        e.active  = 2 * n * e.h;
        e.samples = n;
        e.shifts  = m_cpha ? n : n - 1;
        e.cpol    = m_cpol;
        e.cpha    = m_cpha;
        e.gap     = gap;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input bit we, input int div, input int len,
                               input int cpol, input int cpha);
        if (we) begin
            cfg_we = 1'b1; cfg_div = 8'(div); cfg_len = 4'(len);
            cfg_cpol = cpol[0]; cfg_cpha = cpha[0];
            m_div = div; m_len = len; m_cpol = cpol; m_cpha = cpha;
        end
        start_n = 1'b0;
        push_burst(-1);
        tick();
        cfg_we  = 1'b0;
        start_n = 1'b1;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (o_idle !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        if (o_idle !== 1'b1) chk("idle_timeout", n, -1);
        tick();
        tick();
    endtask

    task automatic model_reset();
        m_div = 2; m_len = 8; m_cpol = 0; m_cpha = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_idle"}, int'(o_idle), 1);
        chk({tag, "_sclk"}, int'(o_sclk), 0);
        chk({tag, "_strobes"}, int'({o_load, o_shift, o_sample, o_done}), 0);
    endtask

    // Monitor: measure each burst and compare against the queued expectation.
    exp_t cur;
    initial begin
        int since, act, ns, nsh, hmn, hmx, bad, gap, gap_obs;
        bit inb, after, lead, es, esh;
        logic psclk, pidle;
        inb = 0; after = 0; gap = 0; gap_obs = -1; psclk = 0; pidle = 1;
        since = 0; act = 0; ns = 0; nsh = 0; hmn = 0; hmx = 0; bad = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                inb = 0; after = 0;
                exp_q.delete();
            end else begin
                if (o_load) begin
                    if (inb) chk("load_inside_burst", 1, 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_burst", 1, 0);
                        inb = 0;
                    end else begin
                        cur = exp_q.pop_front();
                        inb = 1; act = 0; ns = 0; nsh = 0; bad = 0; since = 0;
                        hmn = 1 << 30; hmx = 0;
                        gap_obs = after ? gap : -1;
                        chk("load_sclk_level", int'(o_sclk), cur.cpol);
                        if (o_shift || o_sample) bad++;
                    end
                end else if (inb) begin
                    since++;
                    if (o_sclk !== psclk) begin
                        if (since < hmn) hmn = since;
                        if (since > hmx) hmx = since;
                        lead = (int'(psclk) == cur.cpol);
                        es   = cur.cpha ? !lead : lead;
                        esh  = cur.cpha ? lead : (!lead && !o_done);
                        if (o_sample !== es || o_shift !== esh) bad++;
                        since = 0;
                    end else if (o_sample || o_shift) begin
                        bad++;
                    end
                end
                if (inb && !o_idle) act++;
                if (inb && o_sample) ns++;
                if (inb && o_shift) nsh++;
                if (inb && o_done) begin
                    chk("active_cycles", act, cur.active);
                    chk("sample_count", ns, cur.samples);
                    chk("shift_count", nsh, cur.shifts);
                    chk("half_min", hmn, cur.h);
                    chk("half_max", hmx, cur.h);
                    chk("strobe_placement", bad, 0);
                    chk("done_sclk_level", int'(o_sclk), cur.cpol);
                    chk("done_with_idle_rise", int'(o_idle && !pidle), 1);
                    if (cur.gap >= 0) chk("idle_gap", gap_obs, cur.gap);
                    inb = 0; after = 1; gap = 1;
                    done_cnt++;
                end else if (!inb) begin
                    if (o_idle && after) gap++;
                    if (o_shift || o_sample || o_done) chk("stray_strobe", 1, 0);
                end
            end
            psclk = o_sclk;
            pidle = o_idle;
        end
    end

    initial begin
        int base, n;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_div = '0; cfg_len = '0;
        cfg_cpol = 1'b0; cfg_cpha = 1'b0; start_n = 1'b1;
        model_reset();
        repeat (4) tick();
        chk_reset_outputs("por");
        rst_n = 1'b1;
        tick();

        start_burst(0, 0, 0, 0, 0);            // reset defaults: div=2 len=8 mode0
        wait_idle(100);
        start_burst(1, 250, 8, 0, 0);
        wait_idle(2100);
        start_burst(1, 2, 0, 1, 1);
        wait_idle(100);
        chk("idle_sclk_cpol1", int'(o_sclk), 1);
        start_burst(1, 5, 3, 0, 1);
        wait_idle(100);
        start_burst(1, 1, 2, 1, 0);
        wait_idle(100);
        start_burst(1, 0, 2, 0, 0);
        wait_idle(100);

        // cfg write while busy must not disturb this burst or the next one
        start_burst(1, 100, 2, 1, 0);
        repeat (50) tick();
        cfg_we = 1'b1; cfg_div = 8'd4; cfg_len = 4'd1; cfg_cpol = 1'b0; cfg_cpha = 1'b1;
        tick();
        cfg_we = 1'b0;
        wait_idle(500);
        start_burst(0, 0, 0, 0, 0);
        wait_idle(500);

        // start held low: three back-to-back bursts
        m_div = 6; m_len = 3; m_cpol = 0; m_cpha = 1;
        cfg_we = 1'b1; cfg_div = 8'd6; cfg_len = 4'd3; cfg_cpol = 1'b0; cfg_cpha = 1'b1;
        push_burst(-1); push_burst(1); push_burst(1);
        start_n = 1'b0;
        base = done_cnt;
        tick();
        cfg_we = 1'b0;
        n = 0;
        while (done_cnt < base + 2 && n < 200) begin tick(); n++; end
        if (done_cnt < base + 2) chk("b2b_timeout", n, -1);
        start_n = 1'b1;
        wait_idle(200);

        // reset mid-burst, held 16 cycles
        start_burst(1, 40, 8, 1, 1);
        repeat (100) tick();
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk_reset_outputs("mid_reset");
        end
        rst_n = 1'b1;
        model_reset();
        tick();
        start_burst(0, 0, 0, 0, 0);
        wait_idle(100);

        for (int i = 0; i < 12; i++) begin
            start_burst(1, int'($urandom_range(0, 40)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            wait_idle(1400);
        end

        repeat (4) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
